serial_subtractor_ctrl: RTL
===========================

SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low; it is the only reset.
REQ-004 The block SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 The block SHALL have port A  input  WIDTH  minuend; sampled on the edge that accepts start.
REQ-006 The block SHALL have port B  input  WIDTH  subtrahend; sampled on the edge that accepts start.
REQ-007 The block SHALL have port busy  output  1  high in RUN and DONE states.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port Diff  output  WIDTH  result A-B modulo 2^WIDTH.
REQ-010 The block SHALL have port Borrow  output  1  final borrow, 1 when A<B (unsigned).

Function
REQ-011 The block SHALL sequence one shared 1-bit subtract datapath bit-serially, LSB first, one bit per clock: two half-subtractor stages plus a borrow flop.
REQ-012 Per bit i: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE: on edge with start=1, latch A and B into shift registers, clear borrow flop, clear bit counter to 0, go to RUN; start=0 stays in IDLE.
REQ-015 RUN: each edge processes bit cnt, shifts the result bit into the result shift register at the MSB end, and increments cnt; on the edge processing bit WIDTH-1, go to DONE.
REQ-016 On the DONE-entry edge, Diff SHALL take the full WIDTH-bit result and Borrow SHALL take the final borrow.
REQ-017 DONE: done=1 for exactly that one cycle; next edge goes to IDLE unconditionally.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 Minimum start-to-start spacing SHALL be WIDTH+2 cycles.
REQ-020 start while busy=1 SHALL be ignored: no queuing, and no disturbance of operands or result.
REQ-021 A and B changes after acceptance SHALL have no effect on the running operation.
REQ-022 Diff and Borrow SHALL hold their last values from DONE until the next DONE-entry edge; they SHALL NOT show partial results during RUN.
REQ-023 The bit counter SHALL be clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.
REQ-024 busy SHALL be high from the cycle after the accepting edge through the DONE cycle inclusive.

Reset
REQ-025 While rst_n=0, the state SHALL be IDLE, and busy, done, Diff, Borrow, the counter, shift registers and borrow flop SHALL all be 0.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort immediately, with no done pulse and outputs cleared to 0.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-028 WIDTH=8, A=5, B=3, start at edge k -> busy 1 from k+1; done pulse after edge k+8; Diff=8'h02, Borrow=0.
REQ-029 A=3, B=5 -> Diff=8'hFE, Borrow=1; A=0, B=0 -> Diff=0, Borrow=0; A=8'hFF, B=8'hFF -> Diff=0, Borrow=0; A=0, B=8'hFF -> Diff=8'h01, Borrow=1.
REQ-030 start re-pulsed at k+3 with A=9, B=1 during an active A=5, B=3 run -> single done pulse, Diff=8'h02; no second operation starts.
REQ-031 rst_n low at k+4 mid-run -> busy, done, Diff, Borrow go to 0 without waiting for a clock; a new start after release gives a correct result.
REQ-032 Back-to-back starts at exact spacing WIDTH+2 -> both accepted; each done carries its own correct result; Diff holds between them.
REQ-033 Random regression: 1000 random A/B with WIDTH in {2, 8, 16} -> Diff=(A-B) mod 2^WIDTH, Borrow=(A<B), done latency exactly WIDTH every time.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one shared 1-bit datapath computes A-B LSB first,
// one bit per clock. The IDLE/RUN/DONE sequencer owns the operand and result shift registers.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a_i, b_i;
  logic h1_d, h1_b;
  logic d_bit, h2_b;
  logic br_next;
  logic last_bit;

  // Two half-subtractor stages: operands first, then the running borrow.
  assign a_i      = a_sr[0];
  assign b_i      = b_sr[0];
  assign h1_d     = a_i ^ b_i;
  assign h1_b     = ~a_i & b_i;
  assign d_bit    = h1_d ^ br;
  assign h2_b     = ~h1_d & br;
  assign br_next  = h1_b | h2_b;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Diff   <= '0;
      Borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d_bit, res_sr[WIDTH-1:1]};
          br     <= br_next;
          // Counter stops at WIDTH-1 rather than wrapping; the visible outputs update only here.
          if (last_bit) begin
            Diff   <= {d_bit, res_sr[WIDTH-1:1]};
            Borrow <= br_next;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
